// File: rtl/calc_entry_ctrl.sv
// ---------------------------------------------------------------------------
// calc_entry_ctrl
//
// Keypad-entry sequencer for the calculator datapath. Digit key events are
// shifted into two packed-BCD operand registers (A then B), an operator is
// latched, and "=" hands the operands to the ALU with a one-cycle start. The
// block then waits for the ALU to finish or for a timeout, whichever comes
// first, and reports the outcome on a sticky error flag.
//
// Parameters
//   DIGITS   BCD digits per operand (operand width = 4*DIGITS)
//   TIMEOUT  cycles spent in S_WAIT without alu_done before a forced error
//
// Ports
//   clk          in   system clock, everything on posedge
//   rst          in   asynchronous, active-high reset
//   digit_valid  in   single-cycle digit key event
//   digit        in   digit value (values above 9 are ignored)
//   op_valid     in   single-cycle operator key event
//   op           in   operator: 0 add, 1 sub, 2 mul, 3 div
//   eq_valid     in   single-cycle "=" event
//   bksp_valid   in   single-cycle backspace event
//   clr_valid    in   single-cycle clear event
//   alu_ready    in   ALU can accept a start
//   alu_done     in   ALU result valid (pulse)
//   alu_error    in   ALU error, qualified by alu_done
//   bcd_a        out  operand A, packed BCD, least significant digit in [3:0]
//   bcd_b        out  operand B, packed BCD
//   alu_op       out  latched operator
//   alu_start    out  one-cycle start pulse to the ALU
//   state_o      out  current state encoding
//   busy         out  high while in S_ISSUE or S_WAIT
//   err          out  sticky error flag
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module calc_entry_ctrl #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  digit_valid,
    input  logic [3:0]            digit,
    input  logic                  op_valid,
    input  logic [1:0]            op,
    input  logic                  eq_valid,
    input  logic                  bksp_valid,
    input  logic                  clr_valid,
    input  logic                  alu_ready,
    input  logic                  alu_done,
    input  logic                  alu_error,
    output logic [4*DIGITS-1:0]   bcd_a,
    output logic [4*DIGITS-1:0]   bcd_b,
    output logic [1:0]            alu_op,
    output logic                  alu_start,
    output logic [2:0]            state_o,
    output logic                  busy,
    output logic                  err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] FULL_CNT   = CW'(DIGITS);
    localparam logic [TW-1:0] TIMEOUT_TW = TW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_A     = 3'd0,
        S_B     = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // A digit is shifted in only if it is a decimal digit, the operand still
    // has room, and it is not a leading zero (a leading zero would consume a
    // digit slot while leaving the value unchanged).
    function automatic logic digit_takes(input logic [3:0] d, input logic [CW-1:0] cnt);
        return (d <= 4'd9) && (cnt != FULL_CNT) && !((d == 4'd0) && (cnt == '0));
    endfunction

    function automatic logic [W-1:0] shift_digit_in(input logic [W-1:0] r, input logic [3:0] d);
        return {r[W-5:0], d};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [CW-1:0]   r_cnt_a;
    logic [CW-1:0]   r_cnt_b;
    logic [1:0]      r_op;
    logic            r_start;
    logic            r_busy;
    logic            r_err;
    logic [TW-1:0]   r_tcnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    state_t          w_state_nxt;
    logic [W-1:0]    w_a_nxt;
    logic [W-1:0]    w_b_nxt;
    logic [CW-1:0]   w_cnt_a_nxt;
    logic [CW-1:0]   w_cnt_b_nxt;
    logic [1:0]      w_op_nxt;
    logic            w_start_nxt;
    logic            w_busy_nxt;
    logic            w_err_nxt;
    logic [TW-1:0]   w_tcnt_nxt;

    // Operand currently being edited (A in S_A, B in S_B) and its edited value
    logic            w_in_b;
    logic [W-1:0]    w_cur_reg;
    logic [CW-1:0]   w_cur_cnt;
    logic [W-1:0]    w_edit_reg;
    logic [CW-1:0]   w_edit_cnt;
    logic [TW-1:0]   w_tcnt_inc;

    assign w_in_b     = (r_state == S_B);
    assign w_cur_reg  = w_in_b ? r_b : r_a;
    assign w_cur_cnt  = w_in_b ? r_cnt_b : r_cnt_a;
    // r_tcnt never exceeds TIMEOUT-1, so the increment cannot wrap.
    assign w_tcnt_inc = r_tcnt + 1'b1;

    // Editing of the active operand. The highest-priority event present
    // claims the cycle even when it turns out to be a no-op, so a backspace
    // on an empty operand still swallows a simultaneous digit.
    always_comb begin
        w_edit_reg = w_cur_reg;
        w_edit_cnt = w_cur_cnt;
        if (bksp_valid) begin
            if (w_cur_cnt != '0) begin
                w_edit_reg = w_cur_reg >> 4;
                w_edit_cnt = w_cur_cnt - 1'b1;
            end
        end else if (!eq_valid && !op_valid && digit_valid) begin
            if (digit_takes(digit, w_cur_cnt)) begin
                w_edit_reg = shift_digit_in(w_cur_reg, digit);
                w_edit_cnt = w_cur_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_cnt_a_nxt = r_cnt_a;
        w_cnt_b_nxt = r_cnt_b;
        w_op_nxt    = r_op;
        w_start_nxt = 1'b0;
        w_err_nxt   = r_err;
        w_tcnt_nxt  = r_tcnt;

        if (clr_valid) begin
            // Abort from anywhere; a late alu_done then lands in S_A where
            // nothing listens to it.
            w_state_nxt = S_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = 2'd0;
            w_err_nxt   = 1'b0;
            w_tcnt_nxt  = '0;
        end else begin
            case (r_state)
                S_A, S_B: begin
                    if (w_in_b) begin
                        w_b_nxt     = w_edit_reg;
                        w_cnt_b_nxt = w_edit_cnt;
                    end else begin
                        w_a_nxt     = w_edit_reg;
                        w_cnt_a_nxt = w_edit_cnt;
                    end
                    if (!bksp_valid) begin
                        if (eq_valid) begin
                            if (w_in_b) begin
                                w_state_nxt = S_ISSUE;
                            end
                        end else if (op_valid) begin
                            w_op_nxt    = op;
                            w_state_nxt = S_B;
                        end
                    end
                end

                S_ISSUE: begin
                    if (alu_ready) begin
                        w_start_nxt = 1'b1;
                        w_tcnt_nxt  = '0;
                        w_state_nxt = S_WAIT;
                    end
                end

                S_WAIT: begin
                    // done is checked first so it wins over a coincident timeout
                    if (alu_done) begin
                        w_err_nxt   = alu_error;
                        w_state_nxt = S_DONE;
                    end else if (w_tcnt_inc == TIMEOUT_TW) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_tcnt_nxt  = w_tcnt_inc;
                    end
                end

                S_DONE: begin
                    // A new digit starts a fresh calculation; op/eq/bksp are
                    // ignored here but still outrank a simultaneous digit.
                    if (!bksp_valid && !eq_valid && !op_valid &&
                        digit_valid && (digit <= 4'd9)) begin
                        w_a_nxt     = {{(W-4){1'b0}}, digit};
                        w_cnt_a_nxt = (digit == 4'd0) ? '0 : CW'(1);
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = S_A;
                    end
                end

                default: begin
                    w_state_nxt = S_A;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt == S_ISSUE) || (w_state_nxt == S_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_A;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_op    <= 2'd0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_cnt_a <= w_cnt_a_nxt;
            r_cnt_b <= w_cnt_b_nxt;
            r_op    <= w_op_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_err   <= w_err_nxt;
            r_tcnt  <= w_tcnt_nxt;
        end
    end

    assign bcd_a     = r_a;
    assign bcd_b     = r_b;
    assign alu_op    = r_op;
    assign alu_start = r_start;
    assign state_o   = r_state;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl (DIGITS=4, TIMEOUT=8). Each stimulus cycle pushes
// the expected register snapshot into a scoreboard queue; after the clock
// edge the snapshot is popped and compared field by field.
module tb_calc_entry_ctrl;

    localparam int DIGITS  = 4;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        op_valid = 1'b0;
    logic [1:0]  op = 2'd0;
    logic        eq_valid = 1'b0;
    logic        bksp_valid = 1'b0;
    logic        clr_valid = 1'b0;
    logic        alu_ready = 1'b0;
    logic        alu_done = 1'b0;
    logic        alu_error = 1'b0;
    logic [15:0] bcd_a;
    logic [15:0] bcd_b;
    logic [1:0]  alu_op;
    logic        alu_start;
    logic [2:0]  state_o;
    logic        busy;
    logic        err;

    calc_entry_ctrl #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .digit_valid(digit_valid), .digit(digit),
        .op_valid(op_valid), .op(op),
        .eq_valid(eq_valid), .bksp_valid(bksp_valid), .clr_valid(clr_valid),
        .alu_ready(alu_ready), .alu_done(alu_done), .alu_error(alu_error),
        .bcd_a(bcd_a), .bcd_b(bcd_b), .alu_op(alu_op), .alu_start(alu_start),
        .state_o(state_o), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        logic        err;
        logic        busy;
        logic        start;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Clock one cycle, drop the single-cycle events, then drain the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        op_valid    = 1'b0;
        eq_valid    = 1'b0;
        bksp_valid  = 1'b0;
        clr_valid   = 1'b0;
        alu_done    = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, ".state"}, 32'(state_o),   32'(e.st));
            check_val({e.tag, ".a"},     32'(bcd_a),     32'(e.a));
            check_val({e.tag, ".b"},     32'(bcd_b),     32'(e.b));
            check_val({e.tag, ".op"},    32'(alu_op),    32'(e.op));
            check_val({e.tag, ".err"},   32'(err),       32'(e.err));
            check_val({e.tag, ".busy"},  32'(busy),      32'(e.busy));
            check_val({e.tag, ".start"}, 32'(alu_start), 32'(e.start));
        end
    endtask

    // Push the expected state after this cycle's stimulus, then run the cycle.
    task automatic cyc(input string tag, input int st, input int a, input int b,
                       input int o, input int e, input int bsy, input int s);
        exp_t x;
        x.tag = tag; x.st = 3'(st); x.a = 16'(a); x.b = 16'(b); x.op = 2'(o);
        x.err = 1'(e); x.busy = 1'(bsy); x.start = 1'(s);
        sb.push_back(x);
        step();
    endtask

    task automatic dg(input int d);
        digit_valid = 1'b1;
        digit = 4'(d);
    endtask

    task automatic opk(input int o);
        op_valid = 1'b1;
        op = 2'(o);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, observed while reset is held
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // 1: digits 1,2,3
        dg(1); cyc("t1_d1", 0, 'h0001, 0, 0, 0, 0, 0);
        dg(2); cyc("t1_d2", 0, 'h0012, 0, 0, 0, 0, 0);
        dg(3); cyc("t1_d3", 0, 'h0123, 0, 0, 0, 0, 0);

        // 2: fill, overflow digit, backspace down to empty and beyond
        clr_valid = 1'b1; cyc("t2_clr", 0, 0, 0, 0, 0, 0, 0);
        dg(9); cyc("t2_d9", 0, 'h0009, 0, 0, 0, 0, 0);
        dg(8); cyc("t2_d8", 0, 'h0098, 0, 0, 0, 0, 0);
        dg(7); cyc("t2_d7", 0, 'h0987, 0, 0, 0, 0, 0);
        dg(6); cyc("t2_d6", 0, 'h9876, 0, 0, 0, 0, 0);
        dg(5); cyc("t2_full", 0, 'h9876, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t2_bk1", 0, 'h0987, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t2_bk2", 0, 'h0098, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t2_bk3", 0, 'h0009, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t2_bk4", 0, 'h0000, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t2_bk_under", 0, 'h0000, 0, 0, 0, 0, 0);
        dg(0); cyc("t2_lead0", 0, 'h0000, 0, 0, 0, 0, 0);
        dg(7); cyc("t2_d7b", 0, 'h0007, 0, 0, 0, 0, 0);
        dg(12); cyc("t2_dig_gt9", 0, 'h0007, 0, 0, 0, 0, 0);

        // 3: A=12 op=2 B=34, eq, ALU not ready for 3 cycles
        clr_valid = 1'b1; cyc("t3_clr", 0, 0, 0, 0, 0, 0, 0);
        dg(1); cyc("t3_a1", 0, 'h0001, 0, 0, 0, 0, 0);
        dg(2); cyc("t3_a2", 0, 'h0012, 0, 0, 0, 0, 0);
        opk(2); cyc("t3_op2", 1, 'h0012, 0, 2, 0, 0, 0);
        dg(3); cyc("t3_b3", 1, 'h0012, 'h0003, 2, 0, 0, 0);
        opk(1); cyc("t3_op_ovr", 1, 'h0012, 'h0003, 1, 0, 0, 0);
        opk(2); cyc("t3_op_back", 1, 'h0012, 'h0003, 2, 0, 0, 0);
        dg(4); cyc("t3_b4", 1, 'h0012, 'h0034, 2, 0, 0, 0);
        eq_valid = 1'b1; cyc("t3_eq", 2, 'h0012, 'h0034, 2, 0, 1, 0);
        cyc("t3_nr1", 2, 'h0012, 'h0034, 2, 0, 1, 0);
        dg(9); opk(0); cyc("t3_nr2_drop", 2, 'h0012, 'h0034, 2, 0, 1, 0);
        cyc("t3_nr3", 2, 'h0012, 'h0034, 2, 0, 1, 0);
        alu_ready = 1'b1; cyc("t3_start", 3, 'h0012, 'h0034, 2, 0, 1, 1);
        alu_ready = 1'b0; cyc("t3_start_off", 3, 'h0012, 'h0034, 2, 0, 1, 0);
        alu_done = 1'b1; alu_error = 1'b0; cyc("t3_done", 4, 'h0012, 'h0034, 2, 0, 0, 0);
        bksp_valid = 1'b1; cyc("t3_done_bk", 4, 'h0012, 'h0034, 2, 0, 0, 0);

        // 4: timeout after exactly TIMEOUT cycles in S_WAIT
        dg(7); cyc("t4_new", 0, 'h0007, 0, 2, 0, 0, 0);
        opk(0); cyc("t4_op0", 1, 'h0007, 0, 0, 0, 0, 0);
        dg(1); cyc("t4_b1", 1, 'h0007, 'h0001, 0, 0, 0, 0);
        alu_ready = 1'b1;
        eq_valid = 1'b1; cyc("t4_eq", 2, 'h0007, 'h0001, 0, 0, 1, 0);
        cyc("t4_start", 3, 'h0007, 'h0001, 0, 0, 1, 1);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            if (i == 3) dg(2);
            cyc($sformatf("t4_wait%0d", i), 3, 'h0007, 'h0001, 0, 0, 1, 0);
        end
        cyc("t4_timeout", 4, 'h0007, 'h0001, 0, 1, 0, 0);
        dg(5); cyc("t4_d5", 0, 'h0005, 0, 0, 0, 0, 0);

        // Done coinciding with the timeout cycle: done wins
        opk(1); cyc("t4b_op1", 1, 'h0005, 0, 1, 0, 0, 0);
        dg(2); cyc("t4b_b2", 1, 'h0005, 'h0002, 1, 0, 0, 0);
        eq_valid = 1'b1; cyc("t4b_eq", 2, 'h0005, 'h0002, 1, 0, 1, 0);
        cyc("t4b_start", 3, 'h0005, 'h0002, 1, 0, 1, 1);
        for (int i = 0; i < TIMEOUT - 1; i++)
            cyc($sformatf("t4b_wait%0d", i), 3, 'h0005, 'h0002, 1, 0, 1, 0);
        alu_done = 1'b1; alu_error = 1'b0; cyc("t4b_done_wins", 4, 'h0005, 'h0002, 1, 0, 0, 0);

        // ALU-reported error, leading zero in B
        dg(3); cyc("t4c_d3", 0, 'h0003, 0, 1, 0, 0, 0);
        opk(3); cyc("t4c_op3", 1, 'h0003, 0, 3, 0, 0, 0);
        dg(0); cyc("t4c_b_lead0", 1, 'h0003, 0, 3, 0, 0, 0);
        eq_valid = 1'b1; cyc("t4c_eq", 2, 'h0003, 0, 3, 0, 1, 0);
        cyc("t4c_start", 3, 'h0003, 0, 3, 0, 1, 1);
        alu_done = 1'b1; alu_error = 1'b1; cyc("t4c_alu_err", 4, 'h0003, 0, 3, 1, 0, 0);

        // 5: clr clears sticky err; clr in S_WAIT aborts, late done ignored
        alu_error = 1'b0;
        clr_valid = 1'b1; cyc("t5_clr_done", 0, 0, 0, 0, 0, 0, 0);
        dg(4); cyc("t5_a4", 0, 'h0004, 0, 0, 0, 0, 0);
        opk(0); cyc("t5_op0", 1, 'h0004, 0, 0, 0, 0, 0);
        dg(6); cyc("t5_b6", 1, 'h0004, 'h0006, 0, 0, 0, 0);
        opk(3); cyc("t5_op3", 1, 'h0004, 'h0006, 3, 0, 0, 0);
        eq_valid = 1'b1; cyc("t5_eq", 2, 'h0004, 'h0006, 3, 0, 1, 0);
        cyc("t5_start", 3, 'h0004, 'h0006, 3, 0, 1, 1);
        cyc("t5_wait", 3, 'h0004, 'h0006, 3, 0, 1, 0);
        clr_valid = 1'b1; cyc("t5_clr_wait", 0, 0, 0, 0, 0, 0, 0);
        alu_done = 1'b1; alu_error = 1'b1; cyc("t5_late_done", 0, 0, 0, 0, 0, 0, 0);
        alu_error = 1'b0; alu_ready = 1'b0;

        // 6: same-cycle priority
        clr_valid = 1'b1; dg(5); cyc("t6_clr_dig", 0, 0, 0, 0, 0, 0, 0);
        dg(1); cyc("t6_d1", 0, 'h0001, 0, 0, 0, 0, 0);
        bksp_valid = 1'b1; opk(3); cyc("t6_bk_op", 0, 0, 0, 0, 0, 0, 0);
        eq_valid = 1'b1; cyc("t6_eq_in_a", 0, 0, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
